// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and data memory (slave).
interface mem_stage_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: EX/MEM register, word load/store over a req/ack bus,
// branch resolution and MEM/WB result pulse, with a bounded wait on the data memory.
module mem_stage #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_reg_write,
    input  logic        ex_branch,
    input  logic        ex_zero,
    input  logic [31:0] ex_pc_branch,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rt_val,
    input  logic [4:0]  ex_reg_dst_addr,
    mem_stage_if.master dmem,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_reg_addr,
    output logic [31:0] wb_data,
    output logic        mem_err
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state, state_nx;
    logic               rst_done;
    logic               accept, ack_seen, timeout_hit;
    logic [CNT_W-1:0]   cnt;

    logic               q_mem_read, q_mem_write, q_mem_to_reg, q_reg_write;
    logic               q_branch, q_zero, q_timeout;
    logic [31:0]        q_pc_branch, q_alu_out, q_rt_val, q_rdata;
    logic [4:0]         q_dst;

    // ex_ready stays low during reset and rises on the first edge after release
    assign ex_ready = (state == IDLE) && rst_done;
    assign accept   = ex_valid && ex_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nx;
            rst_done <= 1'b1;
        end
    end

    always_comb begin
        state_nx         = state;
        ack_seen         = 1'b0;
        timeout_hit      = 1'b0;
        dmem.dmem_req    = 1'b0;
        dmem.dmem_we     = 1'b0;
        dmem.dmem_addr   = '0;
        dmem.dmem_wdata  = '0;
        wb_valid         = 1'b0;
        wb_reg_write     = 1'b0;
        wb_reg_addr      = '0;
        wb_data          = '0;
        pc_src           = 1'b0;
        pc_target        = '0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nx = (ex_mem_read || ex_mem_write) ? ACCESS : RESP;
            end
            ACCESS: begin
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = q_mem_write;
                dmem.dmem_addr  = q_alu_out[ADDR_W-1:0];
                dmem.dmem_wdata = q_rt_val;
                ack_seen        = dmem.dmem_ack;
                timeout_hit     = !dmem.dmem_ack && (cnt == CNT_W'(TIMEOUT - 1));
                if (ack_seen || timeout_hit)
                    state_nx = RESP;
            end
            RESP: begin
                state_nx     = IDLE;
                wb_valid     = 1'b1;
                wb_reg_addr  = q_dst;
                wb_data      = q_timeout ? '0 : (q_mem_to_reg ? q_rdata : q_alu_out);
                wb_reg_write = q_reg_write && !q_mem_write && (q_dst != '0) && !q_timeout;
                pc_src       = q_branch && q_zero;
                pc_target    = q_pc_branch;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_mem_read   <= 1'b0;
            q_mem_write  <= 1'b0;
            q_mem_to_reg <= 1'b0;
            q_reg_write  <= 1'b0;
            q_branch     <= 1'b0;
            q_zero       <= 1'b0;
            q_timeout    <= 1'b0;
            q_pc_branch  <= '0;
            q_alu_out    <= '0;
            q_rt_val     <= '0;
            q_rdata      <= '0;
            q_dst        <= '0;
            cnt          <= '0;
            mem_err      <= 1'b0;
        end else if (accept) begin
            q_mem_read   <= ex_mem_read;
            q_mem_write  <= ex_mem_write;
            q_mem_to_reg <= ex_mem_to_reg;
            q_reg_write  <= ex_reg_write;
            q_branch     <= ex_branch;
            q_zero       <= ex_zero;
            q_pc_branch  <= ex_pc_branch;
            q_alu_out    <= ex_alu_out;
            q_rt_val     <= ex_rt_val;
            q_dst        <= ex_reg_dst_addr;
            q_timeout    <= 1'b0;
            q_rdata      <= '0;
            cnt          <= '0;
        end else if (state == ACCESS) begin
            if (ack_seen) begin
                if (!q_mem_write)
                    q_rdata <= dmem.dmem_rdata;
            end else if (timeout_hit) begin
                q_timeout <= 1'b1;
                mem_err   <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of non-memory ops plus hand sequences for memory corners.
module tb_mem_stage;
    logic        clk, rst_n;
    logic        ex_valid, ex_ready;
    logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch, ex_zero;
    logic [31:0] ex_pc_branch, ex_alu_out, ex_rt_val;
    logic [4:0]  ex_reg_dst_addr;
    logic        pc_src, wb_valid, wb_reg_write, mem_err;
    logic [31:0] pc_target, wb_data;
    logic [4:0]  wb_reg_addr;

    int checks = 0;
    int errors = 0;

    mem_stage_if #(.ADDR_W(10)) bus();

    mem_stage #(.ADDR_W(10), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_branch(ex_branch), .ex_zero(ex_zero),
        .ex_pc_branch(ex_pc_branch), .ex_alu_out(ex_alu_out),
        .ex_rt_val(ex_rt_val), .ex_reg_dst_addr(ex_reg_dst_addr),
        .dmem(bus.master),
        .pc_src(pc_src), .pc_target(pc_target),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_reg_addr(wb_reg_addr), .wb_data(wb_data),
        .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic        rw;
        logic [4:0]  dst;
        logic        br;
        logic        z;
        logic [31:0] pcb;
        logic        exp_rw;
        logic [31:0] exp_data;
        logic        exp_pc;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
        ex_reg_write = 0; ex_branch = 0; ex_zero = 0;
        ex_pc_branch = '0; ex_alu_out = '0; ex_rt_val = '0; ex_reg_dst_addr = '0;
    endtask

    task automatic apply_vec(input vec_t v);
        clear_ex();
        ex_valid = 1; ex_alu_out = v.alu; ex_reg_write = v.rw; ex_reg_dst_addr = v.dst;
        ex_branch = v.br; ex_zero = v.z; ex_pc_branch = v.pcb;
        tick();
        ex_valid = 0;
        chk("op wb_valid", wb_valid, 1);
        chk("op wb_reg_write", wb_reg_write, v.exp_rw);
        chk("op wb_reg_addr", wb_reg_addr, v.dst);
        chk("op wb_data", wb_data, v.exp_data);
        chk("op pc_src", pc_src, v.exp_pc);
        if (v.exp_pc) chk("op pc_target", pc_target, v.pcb);
        chk("op ex_ready busy", ex_ready, 0);
        chk("op dmem_req", bus.dmem_req, 0);
        tick();
        chk("op wb_valid drop", wb_valid, 0);
        chk("op pc_src drop", pc_src, 0);
        chk("op ex_ready back", ex_ready, 1);
    endtask

    // Answers requests; ack_at is the 1-based request cycle carrying ack (0 = never)
    task automatic mem_wait(input int ack_at, input logic [31:0] rd, output int nreq);
        nreq = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.dmem_req) break;
            nreq++;
            if (nreq == ack_at) begin
                bus.dmem_ack = 1; bus.dmem_rdata = rd;
            end
            tick();
            bus.dmem_ack = 0; bus.dmem_rdata = '0;
        end
    endtask

    task automatic do_mem(input string name, input logic rd, input logic wr, input logic m2r,
                          input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] rt,
                          input int ack_at, input logic [31:0] rdata,
                          input logic exp_we, input logic [9:0] exp_addr, input int exp_cycles,
                          input logic exp_rw, input logic chk_data, input logic [31:0] exp_data);
        int nreq;
        clear_ex();
        ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_mem_to_reg = m2r;
        ex_reg_write = 1; ex_reg_dst_addr = dst; ex_alu_out = alu; ex_rt_val = rt;
        tick();
        ex_valid = 0;
        chk({name, " dmem_req"}, bus.dmem_req, 1);
        chk({name, " dmem_we"}, bus.dmem_we, exp_we);
        chk({name, " dmem_addr"}, bus.dmem_addr, exp_addr);
        if (exp_we) chk({name, " dmem_wdata"}, bus.dmem_wdata, rt);
        chk({name, " ex_ready busy"}, ex_ready, 0);
        mem_wait(ack_at, rdata, nreq);
        chk({name, " req cycles"}, nreq, exp_cycles);
        chk({name, " wb_valid"}, wb_valid, 1);
        chk({name, " wb_reg_write"}, wb_reg_write, exp_rw);
        chk({name, " wb_reg_addr"}, wb_reg_addr, dst);
        if (chk_data) chk({name, " wb_data"}, wb_data, exp_data);
        tick();
        chk({name, " wb_valid drop"}, wb_valid, 0);
        chk({name, " ex_ready back"}, ex_ready, 1);
    endtask

    initial begin
        int nwb;
        vecs[0] = '{alu:32'h1234, rw:1, dst:5, br:0, z:0, pcb:0, exp_rw:1, exp_data:32'h1234, exp_pc:0};
        vecs[1] = '{alu:32'hFFFF_FFFF, rw:1, dst:0, br:0, z:0, pcb:0, exp_rw:0, exp_data:32'hFFFF_FFFF, exp_pc:0};
        vecs[2] = '{alu:32'h0, rw:0, dst:0, br:1, z:1, pcb:32'h40, exp_rw:0, exp_data:32'h0, exp_pc:1};
        vecs[3] = '{alu:32'h1, rw:0, dst:0, br:1, z:0, pcb:32'h40, exp_rw:0, exp_data:32'h1, exp_pc:0};
        vecs[4] = '{alu:32'hA5A5, rw:0, dst:31, br:0, z:1, pcb:32'h80, exp_rw:0, exp_data:32'hA5A5, exp_pc:0};

        rst_n = 0; clear_ex();
        bus.dmem_ack = 0; bus.dmem_rdata = '0;
        #3;
        chk("reset ex_ready", ex_ready, 0);
        chk("reset dmem_req", bus.dmem_req, 0);
        chk("reset wb_valid", wb_valid, 0);
        chk("reset mem_err", mem_err, 0);
        chk("reset pc_src", pc_src, 0);
        #9 rst_n = 1;
        tick();
        chk("post-reset ex_ready", ex_ready, 1);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Held ex_valid: accept every second cycle
        clear_ex();
        ex_valid = 1; ex_reg_write = 1; ex_reg_dst_addr = 3; ex_alu_out = 7;
        nwb = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wb_valid) nwb++;
        end
        ex_valid = 0;
        chk("throughput wb pulses", nwb, 2);
        tick();

        // Stray ack while idle must be ignored
        bus.dmem_ack = 1; bus.dmem_rdata = 32'h5555_5555;
        tick();
        bus.dmem_ack = 0; bus.dmem_rdata = '0;
        chk("stray ack wb_valid", wb_valid, 0);
        chk("stray ack ex_ready", ex_ready, 1);

        do_mem("load", 1, 0, 1, 5'd8, 32'h10, 32'h0, 3, 32'hDEAD_BEEF,
               0, 10'h010, 3, 1, 1, 32'hDEAD_BEEF);
        do_mem("store", 0, 1, 0, 5'd2, 32'h3FF, 32'hCAFE, 1, 32'h0,
               1, 10'h3FF, 1, 0, 1, 32'h3FF);
        do_mem("wrap", 1, 0, 1, 5'd9, 32'hFFFF_FC10, 32'h0, 2, 32'h1111_2222,
               0, 10'h010, 2, 1, 1, 32'h1111_2222);
        do_mem("rdwr", 1, 1, 1, 5'd4, 32'h5, 32'h77, 1, 32'h9999,
               1, 10'h005, 1, 0, 0, 32'h0);
        chk("mem_err before timeout", mem_err, 0);
        do_mem("timeout", 1, 0, 1, 5'd6, 32'h20, 32'h0, 0, 32'h0,
               0, 10'h020, 16, 0, 1, 32'h0);
        chk("mem_err set", mem_err, 1);
        apply_vec(vecs[0]);
        chk("mem_err sticky", mem_err, 1);

        // Reset in the middle of a load wait
        clear_ex();
        ex_valid = 1; ex_mem_read = 1; ex_mem_to_reg = 1; ex_reg_write = 1;
        ex_reg_dst_addr = 7; ex_alu_out = 32'h30;
        tick();
        ex_valid = 0;
        tick();
        chk("midrst req before", bus.dmem_req, 1);
        #2 rst_n = 0;
        #1;
        chk("midrst req async drop", bus.dmem_req, 0);
        chk("midrst ex_ready", ex_ready, 0);
        chk("midrst mem_err cleared", mem_err, 0);
        tick();
        rst_n = 1;
        nwb = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wb_valid) nwb++;
        end
        chk("midrst no wb_valid", nwb, 0);
        chk("midrst ex_ready back", ex_ready, 1);
        apply_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
